cmd_uart_responder: RTL and testbench

- Knight-side end of the RemoteComm serial link: receives two UART bytes (high byte first) and presents them as a 16-bit command with a ready flag to cmd_proc.
- Serialises 8-bit response codes (e.g. 0xA5 for "calibration done" or "move done") back to the remote.
- Contains its own UART RX and TX engines plus the byte-assembly FSM.
- Sits between the RX/TX pins of KnightsTour and the command processor.

---
 rtl/cmd_uart_responder.sv | 216 +++++++++++++++++++++
 tb/tb_cmd_uart_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_uart_responder.sv
// Knight-side RemoteComm endpoint: UART RX/TX engines plus the two-byte command assembler.
// Commands arrive high byte first; 8-bit response codes go back out on TX.
module cmd_uart_responder #(
    parameter int unsigned BAUD_DIV = 5208,
    parameter int unsigned BYTE_TMO = 2_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);

    localparam int unsigned CntW = $clog2(BAUD_DIV + 1);
    localparam int unsigned TmoW = $clog2(BYTE_TMO + 1);
    localparam logic [CntW-1:0] HalfM1 = CntW'(BAUD_DIV / 2 - 1);
    localparam logic [CntW-1:0] FullM1 = CntW'(BAUD_DIV - 1);
    localparam logic [TmoW-1:0] TmoM1  = TmoW'(BYTE_TMO - 1);

    typedef enum logic {RxIdle, RxRecv} rx_state_e;
    typedef enum logic {WaitHi, WaitLo} asm_state_e;
    typedef enum logic {TxIdle, TxXmit} tx_state_e;

    logic            rx_meta_q, rx_s_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_armed_q, rx_armed_d;
    logic            rx_start, rx_byte_vld, rx_frm_err;

    asm_state_e      asm_state_q, asm_state_d;
    logic [7:0]      hi_q, hi_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [15:0]     cmd_q, cmd_d;
    logic            cmd_rdy_q, cmd_rdy_d;

    tx_state_e       tx_state_q, tx_state_d;
    logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [9:0]      tx_shift_q, tx_shift_d;
    logic            tx_q, tx_d;
    logic            tx_done_q, tx_done_d;

    // A start is only accepted after the line has been seen idle-high, so a line held
    // low across reset or after a framing error is not mistaken for a new frame.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_armed_d  = rx_armed_q;
        rx_start    = 1'b0;
        rx_byte_vld = 1'b0;
        rx_frm_err  = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (rx_s_q) begin
                    rx_armed_d = 1'b1;
                end else if (rx_armed_q) begin
                    rx_start   = 1'b1;
                    rx_armed_d = 1'b0;
                    rx_state_d = RxRecv;
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                end
            end
            RxRecv: begin
                if (rx_cnt_q == (rx_bit_q == 4'd0 ? HalfM1 : FullM1)) begin
                    rx_cnt_d = '0;
                    rx_bit_d = rx_bit_q + 4'd1;
                    if (rx_bit_q == 4'd0) begin
                        if (rx_s_q) rx_state_d = RxIdle;
                    end else if (rx_bit_q == 4'd9) begin
                        rx_state_d  = RxIdle;
                        rx_byte_vld = rx_s_q;
                        rx_frm_err  = ~rx_s_q;
                    end else begin
                        rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CntW'(1);
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_comb begin
        asm_state_d = asm_state_q;
        hi_d        = hi_q;
        tmo_d       = tmo_q;
        cmd_d       = cmd_q;
        cmd_rdy_d   = cmd_rdy_q;
        if (clr_cmd_rdy || (rx_start && asm_state_q == WaitHi)) cmd_rdy_d = 1'b0;
        unique case (asm_state_q)
            WaitHi: begin
                if (rx_byte_vld) begin
                    hi_d        = rx_shift_q;
                    tmo_d       = '0;
                    asm_state_d = WaitLo;
                end
            end
            WaitLo: begin
                if (rx_frm_err) begin
                    hi_d        = '0;
                    asm_state_d = WaitHi;
                end else if (rx_byte_vld) begin
                    cmd_d       = {hi_q, rx_shift_q};
                    cmd_rdy_d   = 1'b1;
                    asm_state_d = WaitHi;
                end else if (rx_state_q == RxIdle && !rx_start) begin
                    if (tmo_q >= TmoM1) begin
                        hi_d        = '0;
                        asm_state_d = WaitHi;
                    end else begin
                        tmo_d = tmo_q + TmoW'(1);
                    end
                end
            end
            default: asm_state_d = WaitHi;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_done_d  = tx_done_q;
        unique case (tx_state_q)
            TxIdle: begin
                tx_d = 1'b1;
                if (trmt) begin
                    tx_shift_d = {1'b1, resp, 1'b0};
                    tx_done_d  = 1'b0;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = 1'b0;
                    tx_state_d = TxXmit;
                end
            end
            TxXmit: begin
                if (tx_cnt_q == FullM1) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 4'd9) begin
                        tx_state_d = TxIdle;
                        tx_done_d  = 1'b1;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 4'd1;
                        tx_shift_d = {1'b1, tx_shift_q[9:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CntW'(1);
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_state_q  <= RxIdle;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_armed_q  <= 1'b0;
            asm_state_q <= WaitHi;
            hi_q        <= '0;
            tmo_q       <= '0;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            tx_state_q  <= TxIdle;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '1;
            tx_q        <= 1'b1;
            tx_done_q   <= 1'b0;
        end else begin
            rx_meta_q   <= RX;
            rx_s_q      <= rx_meta_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_armed_q  <= rx_armed_d;
            asm_state_q <= asm_state_d;
            hi_q        <= hi_d;
            tmo_q       <= tmo_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign TX      = tx_q;
    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_cmd_uart_responder.sv
// Scoreboard bench for cmd_uart_responder: a remote UART model drives RX, monitors
// decode cmd_rdy/cmd and the TX line and compare against queued expectations.
module tb_cmd_uart_responder;

    localparam int unsigned BD  = 16;
    localparam int unsigned TMO = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        trmt = 1'b0;
    logic        tx_done;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int stop_cyc = 0;
    int last_lat = 0;
    int n_rdy    = 0;
    logic rdy_prev = 1'b0;

    logic [15:0] exp_cmd_q[$];
    logic [7:0]  exp_tx_q[$];

    cmd_uart_responder #(.BAUD_DIV(BD), .BYTE_TMO(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .trmt        (trmt),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic uart_send(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            RX = f[i];
            if (i == 9) stop_cyc = cyc;
            repeat (BD - 1) @(posedge clk);
        end
        @(posedge clk);
        #1;
        RX = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic wait_rdy(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (cmd_rdy) break;
        end
        check(tag, {15'd0, cmd_rdy}, 16'd1);
    endtask

    task automatic pulse_trmt(input logic [7:0] r);
        @(posedge clk);
        #1;
        trmt = 1'b1;
        resp = r;
        @(posedge clk);
        #1;
        trmt = 1'b0;
        resp = 8'h00;
    endtask

    // Command scoreboard: every rising cmd_rdy must match the oldest expected command.
    always @(negedge clk) begin
        if (rst_n && cmd_rdy && !rdy_prev) begin
            n_rdy++;
            last_lat = cyc - stop_cyc;
            if (exp_cmd_q.size() == 0) check("cmd_expected", 16'(exp_cmd_q.size()), 16'd1);
            else check("cmd", cmd, exp_cmd_q.pop_front());
        end
        rdy_prev <= cmd_rdy;
    end

    // Remote-side receiver decoding TX at mid-bit.
    initial begin : tx_mon
        logic [7:0] b;
        logic       stp;
        forever begin
            @(negedge clk);
            if (rst_n && TX == 1'b0) begin
                repeat (BD / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    b[i] = TX;
                end
                repeat (BD) @(negedge clk);
                stp = TX;
                if (exp_tx_q.size() == 0) check("tx_expected", 16'(exp_tx_q.size()), 16'd1);
                else check("tx_byte", {7'd0, stp, b}, {7'd0, 1'b1, exp_tx_q.pop_front()});
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [9:0] frame;
        int errs;
        int n0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", {15'd0, TX}, 16'd1);
        check("rst_cmd", cmd, 16'h0000);
        check("rst_rdy", {15'd0, cmd_rdy}, 16'd0);
        check("rst_done", {15'd0, tx_done}, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);

        // Basic command 0x4022, latency and clear
        uart_send(8'h40, 1'b1);
        exp_cmd_q.push_back(16'h4022);
        uart_send(8'h22, 1'b1);
        wait_rdy("rdy_4022", 40);
        check("rdy_latency", 16'(last_lat), 16'd11);
        @(posedge clk);
        #1;
        clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        clr_cmd_rdy = 1'b0;
        @(negedge clk);
        check("clr_rdy", {15'd0, cmd_rdy}, 16'd0);
        check("cmd_hold", cmd, 16'h4022);

        // Transmit 0xA5 cycle-exact, with an ignored second trmt
        frame = {1'b1, 8'hA5, 1'b0};
        exp_tx_q.push_back(8'hA5);
        pulse_trmt(8'hA5);
        errs = 0;
        for (int k = 0; k < 160; k++) begin
            @(negedge clk);
            if (k == 0) check("tx_done_clr", {15'd0, tx_done}, 16'd0);
            if (TX !== frame[k / 16]) errs++;
            if (k == 39) begin
                trmt = 1'b1;
                resp = 8'hFF;
            end
            if (k == 40) begin
                trmt = 1'b0;
                resp = 8'h00;
            end
        end
        check("tx_wave_errs", 16'(errs), 16'd0);
        @(negedge clk);
        check("tx_done_set", {15'd0, tx_done}, 16'd1);
        check("tx_idle", {15'd0, TX}, 16'd1);
        idle(3 * BD);

        // Byte timeout drops the lone high byte
        n0 = n_rdy;
        uart_send(8'h12, 1'b1);
        idle(150);
        uart_send(8'h34, 1'b1);
        exp_cmd_q.push_back(16'h3456);
        uart_send(8'h56, 1'b1);
        wait_rdy("rdy_3456", 40);
        idle(BD);
        check("tmo_rdy_count", 16'(n_rdy - n0), 16'd1);

        // Reset in the middle of the low byte of 0xBEEF
        uart_send(8'hBE, 1'b1);
        fork
            uart_send(8'hEF, 1'b1);
            begin
                idle(5 * BD);
                #1;
                rst_n = 1'b0;
                @(negedge clk);
                check("mid_rst_cmd", cmd, 16'h0000);
                check("mid_rst_rdy", {15'd0, cmd_rdy}, 16'd0);
                check("mid_rst_tx", {15'd0, TX}, 16'd1);
                check("mid_rst_done", {15'd0, tx_done}, 16'd0);
            end
        join
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);
        uart_send(8'hBE, 1'b1);
        exp_cmd_q.push_back(16'hBEEF);
        uart_send(8'hEF, 1'b1);
        wait_rdy("rdy_beef", 40);

        // Framing error resets pairing
        n0 = n_rdy;
        uart_send(8'h00, 1'b0);
        idle(BD);
        check("frm_cmd_hold", cmd, 16'hBEEF);
        check("frm_rdy_clr", {15'd0, cmd_rdy}, 16'd0);
        uart_send(8'h00, 1'b1);
        exp_cmd_q.push_back(16'h0000);
        uart_send(8'h00, 1'b1);
        wait_rdy("rdy_0000", 40);
        idle(BD);
        check("frm_rdy_count", 16'(n_rdy - n0), 16'd1);

        // Full duplex
        n0 = n_rdy;
        exp_tx_q.push_back(8'hA5);
        fork
            pulse_trmt(8'hA5);
            begin
                idle(BD / 2);
                uart_send(8'h00, 1'b1);
                exp_cmd_q.push_back(16'h0000);
                uart_send(8'h00, 1'b1);
            end
        join
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_done && exp_tx_q.size() == 0 && exp_cmd_q.size() == 0) break;
        end
        check("dup_rdy", {15'd0, cmd_rdy}, 16'd1);
        check("dup_done", {15'd0, tx_done}, 16'd1);
        check("dup_rdy_count", 16'(n_rdy - n0), 16'd1);
        check("cmd_q_empty", 16'(exp_cmd_q.size()), 16'd0);
        check("tx_q_empty", 16'(exp_tx_q.size()), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
